// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- small sequential ALU with a multi-cycle shift-add multiplier.
//
// Single-cycle ops (add, sub, and, or, shl, shr, pass) update the result and
// flags on the edge that samples start and pulse done in the following cycle.
// Multiply (op 3'b110) captures both operands, then runs WIDTH shift-add
// steps while busy is high. It writes the low half of the product to t and
// the high half to h, then pulses done.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   start  in   1      operation request (ignored while busy)
//   op     in   3      operation code, sampled with start
//   s      in   WIDTH  operand A
//   d      in   WIDTH  operand B
//   t      out  WIDTH  registered result
//   h      out  WIDTH  registered high half of the last multiply
//   cf     out  1      registered carry / borrow flag
//   zf     out  1      registered zero flag
//   busy   out  1      multiply in progress
//   done   out  1      one-cycle pulse: result valid
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] h,
    output logic             cf,
    output logic             zf,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_t;
    logic [WIDTH-1:0]   r_h;
    logic               r_cf;
    logic               r_zf;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_alu;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;

    // Single-cycle result: the MSB is the flag (carry/borrow/shifted-out bit),
    // and the low WIDTH bits are the result. Multiply is not handled here.
    function automatic logic [WIDTH:0] f_alu(
        input logic [2:0]       i_op,
        input logic [WIDTH-1:0] i_a,
        input logic [WIDTH-1:0] i_b
    );
        logic [WIDTH:0] v;
        v = '0;
        case (i_op)
            OP_ADD:  v = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  v = {(i_a < i_b), i_a - i_b};
            OP_AND:  v = {1'b0, i_a & i_b};
            OP_OR:   v = {1'b0, i_a | i_b};
            OP_SHL:  v = {i_a[WIDTH-1], i_a[WIDTH-2:0], 1'b0};
            OP_SHR:  v = {i_a[0], 1'b0, i_a[WIDTH-1:1]};
            OP_PASS: v = {1'b0, i_a};
            default: v = {1'b0, i_a};
        endcase
        return v;
    endfunction

    // ALU result and the next multiply accumulator value. The step index
    // selects the multiplier bit and the multiplicand shift amount.
    always_comb begin
        w_alu    = f_alu(op, s, d);
        w_addend = '0;
        if (r_mplier[r_cnt]) begin
            w_addend = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
        end else begin
            w_addend = '0;
        end
        w_acc_next = r_acc + w_addend;
    end

    // Control FSM, result and flag registers, and multiplier datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_t      <= '0;
            r_h      <= '0;
            r_cf     <= 1'b0;
            r_zf     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (op == OP_MUL) begin
                            r_mcand  <= s;
                            r_mplier <= d;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_MUL;
                        end else begin
                            r_t    <= w_alu[WIDTH-1:0];
                            r_cf   <= w_alu[WIDTH];
                            r_zf   <= (w_alu[WIDTH-1:0] == '0);
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    // start is ignored here; operands come only from the
                    // captured copies, so live s/d/op have no effect.
                    r_done <= 1'b0;
                    r_acc  <= w_acc_next;
                    if (r_cnt == LAST_STEP) begin
                        r_t     <= w_acc_next[WIDTH-1:0];
                        r_h     <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_cf    <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_zf    <= (w_acc_next == '0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign t    = r_t;
    assign h    = r_h;
    assign cf   = r_cf;
    assign zf   = r_zf;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; all values below are for WIDTH=8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  operation request, sampled on rising edge.
REQ-005 op  input  3  operation code, sampled with start.
REQ-006 s  input  WIDTH  operand A, driven by the register group s port.
REQ-007 d  input  WIDTH  operand B, driven by the register group d port.
REQ-008 t  output  WIDTH  registered result; drives the register group i input.
REQ-009 h  output  WIDTH  registered high byte of last multiply.
REQ-010 cf  output  1  registered carry/borrow flag.
REQ-011 zf  output  1  registered zero flag.
REQ-012 busy  output  1  high while a multiply is in progress.
REQ-013 done  output  1  one-cycle pulse marking result valid.

Function
REQ-014 Op codes SHALL be: 000 add, 001 sub (s-d), 010 and, 011 or, 100 shl s by 1, 101 shr s by 1, 110 multiply s*d unsigned, 111 pass s.
REQ-015 States SHALL be IDLE and MUL; reset and power-up state IDLE.
REQ-016 In IDLE, start=1 with op!=110 at edge E0 SHALL update t, cf, zf at E0 and assert done for the cycle after E0; state stays IDLE.
REQ-017 In IDLE, start=1 with op=110 at E0 SHALL latch s, d into internal operand registers, clear a 16-bit accumulator, load step counter 0, enter MUL, assert busy.
REQ-018 In MUL, each edge E1..E8 SHALL perform one shift-add step (add shifted multiplicand when current multiplier bit is 1).
REQ-019 At E8 SHALL write t=product[7:0], h=product[15:8], cf=|product[15:8], zf=(product==0), return to IDLE, drop busy, assert done for the following cycle.
REQ-020 busy SHALL be high in the cycles after E0 through E8 exclusive of the done cycle; done and busy never high together.
REQ-021 Flags: add cf=carry out of bit 7; sub cf=1 iff s<d unsigned; and/or/pass cf=0; shl cf=s[7], t=s<<1; shr cf=s[0], t=s>>1 (zero fill).
REQ-022 zf SHALL be 1 iff the new t is zero (multiply: full 16-bit product zero).
REQ-023 Add/sub results SHALL wrap modulo 256.
REQ-024 h SHALL change only on multiply completion; other ops leave h unchanged.
REQ-025 start while busy SHALL be ignored: no state, output, or operand change; no queuing.
REQ-026 Changes on s, d, op during MUL SHALL not affect the product.
REQ-027 start in the done cycle SHALL be accepted normally (back-to-back issue).
REQ-028 Without start, t, h, cf, zf SHALL hold; done SHALL be 0.

Reset
REQ-029 rst=1 SHALL set t=0, h=0, cf=0, zf=0, busy=0, done=0, counter=0, state IDLE at that edge.
REQ-030 rst SHALL take priority over start; rst during MUL SHALL abort the multiply with no done pulse.
REQ-031 After rst deasserts, first start SHALL be accepted on the next edge.

Verification
REQ-032 s=8'hF0, d=8'h20, op=000, start one cycle -> next cycle t=8'h10, cf=1, zf=0, done=1 for one cycle.
REQ-033 s=8'h05, d=8'h07, op=001 -> t=8'hFE, cf=1, zf=0; then s=d=8'h33, op=001 -> t=8'h00, cf=0, zf=1.
REQ-034 s=8'h81, op=100 -> t=8'h02, cf=1; s=8'h81, op=101 -> t=8'h40, cf=1; h unchanged.
REQ-035 s=8'h0F, d=8'h11, op=110; change s, d and pulse start mid-operation -> busy 8 cycles, then t=8'hFF, h=8'h00, cf=0, zf=0, single done pulse.
REQ-036 s=8'hFF, d=8'hFF, op=110 -> t=8'h01, h=8'hFE, cf=1; repeat with d=0 -> t=0, h=0, zf=1.
REQ-037 Start multiply, assert rst at step 4 -> all outputs zero, busy=0, no done; next add accepted immediately.
